sram_like_arbiter: RTL and testbench

//  Shares one sram-like bus port between the instruction-side and data-side sram-like masters of the core.

---
 rtl/sram_like_arbiter_pkg.sv | 18 +
 rtl/sram_like_arbiter_arb_pick2.sv | 29 ++
 rtl/sram_like_arbiter.sv | 113 +++++++++++
 tb/tb_sram_like_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared codes for the sram-like arbiter: FSM states, owner ids, sizes.
// Imported by arb_pick2 and sram_like_arbiter.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_arb_pick2.sv
// arb_pick2: 2-way I/D winner select. Ports: req_i, req_d, last -> grant.
// ARB_ROUND_ROBIN_EN: tie goes to master != last; else data wins ties.
module arb_pick2
  import sram_like_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic grant
);

  always_comb begin
    grant = OWN_D;
    unique case (1'b1)
      (req_i & ~req_d): grant = OWN_I;
      (req_d & ~req_i): grant = OWN_D;
      (req_i & req_d): begin
`ifdef ARB_ROUND_ROBIN_EN
        grant = ~last;
`else
        // a stalled load/store freezes the pipe
        grant = OWN_D;
`endif
      end
      default: grant = OWN_D;
    endcase
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between I and D masters, one txn in flight.
// Ports: clk, rst, mi_*/md_* masters, s_* slave. Macro: ARB_ROUND_ROBIN_EN.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mi_req,
  input  logic          mi_wr,
  input  logic [1:0]    mi_size,
  input  logic [AW-1:0] mi_addr,
  input  logic [DW-1:0] mi_wdata,
  output logic          mi_addr_ok,
  output logic          mi_data_ok,
  output logic [DW-1:0] mi_rdata,
  input  logic          md_req,
  input  logic          md_wr,
  input  logic [1:0]    md_size,
  input  logic [AW-1:0] md_addr,
  input  logic [DW-1:0] md_wdata,
  output logic          md_addr_ok,
  output logic          md_data_ok,
  output logic [DW-1:0] md_rdata,
  output logic          s_req,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_addr_ok,
  input  logic          s_data_ok,
  input  logic [DW-1:0] s_rdata
);

  state_t        state;
  logic          owner;
  logic          last;
  logic          grant;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  arb_pick2 u_pick (
    .req_i (mi_req),
    .req_d (md_req),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWN_I;
      last    <= OWN_D;
      wr_q    <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mi_req | md_req) begin
            owner   <= grant;
            wr_q    <= grant ? md_wr : mi_wr;
            size_q  <= grant ? md_size : mi_size;
            addr_q  <= grant ? md_addr : mi_addr;
            wdata_q <= grant ? md_wdata : mi_wdata;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // addr_ok wins over a same-cycle data_ok
          if (s_addr_ok) state <= ST_DATA;
        end
        ST_DATA: begin
          if (s_data_ok) begin
            last  <= owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic in_addr;
  logic in_data;
  logic addr_hit;
  logic data_hit;

  // rst masks outputs so a response in the reset cycle is dropped
  assign in_addr  = (state == ST_ADDR) & ~rst;
  assign in_data  = (state == ST_DATA) & ~rst;
  assign addr_hit = in_addr & s_addr_ok;
  assign data_hit = in_data & s_data_ok;

  assign s_req   = in_addr;
  assign s_wr    = in_addr & wr_q;
  assign s_size  = in_addr ? size_q : SZ_B;
  assign s_addr  = in_addr ? addr_q : '0;
  assign s_wdata = in_addr ? wdata_q : '0;

  assign mi_addr_ok = addr_hit & (owner == OWN_I);
  assign md_addr_ok = addr_hit & (owner == OWN_D);
  assign mi_data_ok = data_hit & (owner == OWN_I);
  assign md_data_ok = data_hit & (owner == OWN_D);
  assign mi_rdata   = mi_data_ok ? s_rdata : '0;
  assign md_rdata   = md_data_ok ? s_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed + random checks for sram_like_arbiter.
// Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mi_req, mi_wr, md_req, md_wr;
  logic [1:0]  mi_size, md_size, s_size;
  logic [31:0] mi_addr, mi_wdata, md_addr, md_wdata;
  logic        mi_addr_ok, mi_data_ok, md_addr_ok, md_data_ok;
  logic [31:0] mi_rdata, md_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .mi_req(mi_req), .mi_wr(mi_wr), .mi_size(mi_size),
    .mi_addr(mi_addr), .mi_wdata(mi_wdata),
    .mi_addr_ok(mi_addr_ok), .mi_data_ok(mi_data_ok),
    .mi_rdata(mi_rdata),
    .md_req(md_req), .md_wr(md_wr), .md_size(md_size),
    .md_addr(md_addr), .md_wdata(md_wdata),
    .md_addr_ok(md_addr_ok), .md_data_ok(md_data_ok),
    .md_rdata(md_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic tie_win(input logic lst);
`ifdef ARB_ROUND_ROBIN_EN
    return ~lst;
`else
    return 1'b1;
`endif
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_s_req"}, s_req, 0);
    chk({tag, "_s_wr"}, s_wr, 0);
    chk({tag, "_s_size"}, s_size, 0);
    chk({tag, "_s_addr"}, s_addr, 0);
    chk({tag, "_s_wdata"}, s_wdata, 0);
    chk({tag, "_m_ok"},
        {mi_addr_ok, mi_data_ok, md_addr_ok, md_data_ok}, 0);
    chk({tag, "_mi_rdata"}, mi_rdata, 0);
    chk({tag, "_md_rdata"}, md_rdata, 0);
  endtask

  logic        pend_i, pend_d, last_m, exp_o;
  logic [1:0]  ph;
  logic        own;
  logic [31:0] own_addr;
  logic        out_i, out_d, e_ai, e_ad, e_di, e_dd;
  int          iss_i, iss_d, aok_i, aok_d, dok_i, dok_d, pulses;

  initial begin
    rst = 1'b1;
    mi_req = 0; mi_wr = 0; mi_size = 0; mi_addr = 0; mi_wdata = 0;
    md_req = 0; md_wr = 0; md_size = 0; md_addr = 0; md_wdata = 0;
    s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
    step();
    step();
    #1;
    all_zero("reset");

    // test 1: lone I read
    step();
    rst = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    mi_req = 1; mi_addr = 32'hBFC0_0000; mi_size = 2'd2;
    #1 chk("t1_grant_no_sreq", s_req, 0);
    step();
    #1 chk("t1_c1_sreq", s_req, 1);
    chk("t1_c1_saddr", s_addr, 32'hBFC0_0000);
    chk("t1_c1_swr", s_wr, 0);
    chk("t1_c1_ssize", s_size, 2);
    step();
    #1 chk("t1_c2_sreq", s_req, 1);
    chk("t1_c2_no_aok", mi_addr_ok, 0);
    step();
    s_addr_ok = 1;
    #1 chk("t1_c3_mi_aok", mi_addr_ok, 1);
    chk("t1_c3_md_aok", md_addr_ok, 0);
    step();
    s_addr_ok = 0; mi_req = 0;
    #1 chk("t1_c4_sreq", s_req, 0);
    chk("t1_c4_no_dok", mi_data_ok, 0);
    step();
    s_data_ok = 1; s_rdata = 32'h3C08_BFAF;
    #1 chk("t1_c5_mi_dok", mi_data_ok, 1);
    chk("t1_c5_mi_rdata", mi_rdata, 32'h3C08_BFAF);
    chk("t1_c5_md_dok", md_data_ok, 0);
    chk("t1_c5_md_rdata", md_rdata, 0);
    step();
    s_data_ok = 0; s_rdata = 0;
    #1 chk("t1_c6_idle", s_req, 0);

    // test 4: D half write with a slow addr_ok
    md_req = 1; md_wr = 1; md_size = 2'd1;
    md_addr = 32'h8000_1002; md_wdata = 32'h0000_BEEF;
    pulses = 0;
    step();
    for (int k = 0; k < 6; k++) begin
      #1 chk("t4_sreq", s_req, 1);
      chk("t4_swr", s_wr, 1);
      chk("t4_ssize", s_size, 1);
      chk("t4_saddr", s_addr, 32'h8000_1002);
      chk("t4_swdata", s_wdata, 32'h0000_BEEF);
      if (md_addr_ok) pulses++;
      step();
    end
    s_addr_ok = 1;
    #1 if (md_addr_ok) pulses++;
    chk("t4_mi_aok", mi_addr_ok, 0);
    step();
    s_addr_ok = 0; md_req = 0; md_wr = 0;
    #1 if (md_addr_ok) pulses++;
    chk("t4_aok_once", pulses, 1);
    chk("t4_data_sreq", s_req, 0);
    step();
    s_data_ok = 1;
    #1 chk("t4_md_dok", md_data_ok, 1);
    chk("t4_mi_dok", mi_data_ok, 0);
    step();
    s_data_ok = 0;

    // tests 2/3: contention, last = D here
    pend_i = 1; pend_d = 1; last_m = 1;
    mi_addr = 32'h0000_1000; md_addr = 32'h0000_2000;
    mi_size = 2'd2; md_size = 2'd2;
    for (int n = 0; n < 5; n++) begin
      mi_req = pend_i; md_req = pend_d;
      #1 chk("tie_idle_gap", s_req, 0);
      exp_o = (pend_i && pend_d) ? tie_win(last_m) : pend_d;
      step();
      #1 chk("tie_winner_addr", s_addr,
             exp_o ? 32'h0000_2000 : 32'h0000_1000);
      s_addr_ok = 1;
      #1 chk("tie_aok", {mi_addr_ok, md_addr_ok}, {~exp_o, exp_o});
      step();
      s_addr_ok = 0;
      if (exp_o) begin pend_d = 0; md_req = 0; end
      else begin pend_i = 0; mi_req = 0; end
      s_data_ok = 1; s_rdata = 32'hA000_0000 + n;
      #1 chk("tie_dok", {mi_data_ok, md_data_ok}, {~exp_o, exp_o});
      chk("tie_rdata", exp_o ? md_rdata : mi_rdata,
          32'hA000_0000 + n);
      step();
      s_data_ok = 0;
      last_m = exp_o;
      if (n < 3) begin
        if (exp_o) pend_d = 1;
        else pend_i = 1;
      end
    end

    // test 5: reset in DATA, stale data_ok afterwards
    mi_req = 1; mi_addr = 32'h0000_4000;
    step();
    s_addr_ok = 1;
    step();
    s_addr_ok = 0; mi_req = 0;
    rst = 1; s_data_ok = 1; s_rdata = 32'h0000_1234;
    #1 all_zero("t5_rst");
    step();
    rst = 0;
    #1 all_zero("t5_stale");
    step();
    s_data_ok = 0;
    md_req = 1; md_addr = 32'h0000_5000;
    #1 chk("t5_idle_grant", s_req, 0);
    step();
    #1 chk("t5_sreq", s_req, 1);
    chk("t5_saddr", s_addr, 32'h0000_5000);
    s_addr_ok = 1; s_data_ok = 1;
    #1 chk("t5_both_aok", md_addr_ok, 1);
    chk("t5_both_no_dok", md_data_ok, 0);
    step();
    md_req = 0; s_addr_ok = 0; s_data_ok = 0;
    #1 chk("t5_wait_dok", md_data_ok, 0);
    step();
    s_data_ok = 1; s_rdata = 32'h0000_5555;
    #1 chk("t5_dok", md_data_ok, 1);
    chk("t5_rdata", md_rdata, 32'h0000_5555);
    step();
    s_data_ok = 0;

    // test 6: random traffic against a model
    ph = 0; own = 0; own_addr = 0; last_m = 1;
    out_i = 0; out_d = 0;
    iss_i = 0; iss_d = 0; aok_i = 0; aok_d = 0; dok_i = 0; dok_d = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 500) begin
        if (!out_i && $urandom_range(0, 2) == 0) begin
          out_i = 1; mi_req = 1; iss_i++;
          mi_addr = $urandom; mi_wdata = $urandom;
          mi_wr = 1'($urandom_range(0, 1));
          mi_size = 2'($urandom_range(0, 2));
        end
        if (!out_d && $urandom_range(0, 2) == 0) begin
          out_d = 1; md_req = 1; iss_d++;
          md_addr = $urandom; md_wdata = $urandom;
          md_wr = 1'($urandom_range(0, 1));
          md_size = 2'($urandom_range(0, 2));
        end
      end
      s_addr_ok = (ph == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data_ok = (ph != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_rdata = $urandom;
      #1;
      e_ai = (ph == 1) && s_addr_ok && !own;
      e_ad = (ph == 1) && s_addr_ok && own;
      e_di = (ph == 2) && s_data_ok && !own;
      e_dd = (ph == 2) && s_data_ok && own;
      chk("rnd_sreq", s_req, ph == 1);
      if (ph == 1) chk("rnd_saddr", s_addr, own_addr);
      chk("rnd_aok", {mi_addr_ok, md_addr_ok}, {e_ai, e_ad});
      chk("rnd_dok", {mi_data_ok, md_data_ok}, {e_di, e_dd});
      chk("rnd_mi_rdata", mi_rdata, e_di ? s_rdata : 32'h0);
      chk("rnd_md_rdata", md_rdata, e_dd ? s_rdata : 32'h0);
      if (mi_addr_ok) aok_i++;
      if (md_addr_ok) aok_d++;
      if (mi_data_ok) dok_i++;
      if (md_data_ok) dok_d++;
      case (ph)
        2'd0: if (mi_req || md_req) begin
          own = (mi_req && md_req) ? tie_win(last_m) : md_req;
          own_addr = own ? md_addr : mi_addr;
          ph = 1;
        end
        2'd1: if (s_addr_ok) begin
          ph = 2;
          if (own) md_req = 0;
          else mi_req = 0;
        end
        default: if (s_data_ok) begin
          last_m = own;
          ph = 0;
          if (own) out_d = 0;
          else out_i = 0;
        end
      endcase
      step();
    end
    s_addr_ok = 0; s_data_ok = 0;
    chk("rnd_drained", {out_i, out_d}, 0);
    chk("rnd_i_aok_cnt", aok_i, iss_i);
    chk("rnd_i_dok_cnt", dok_i, iss_i);
    chk("rnd_d_aok_cnt", aok_d, iss_d);
    chk("rnd_d_dok_cnt", dok_d, iss_d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
